// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC, PC step,
// FSM state encoding and the PC adder helper.
package fetch_unit_pkg;

    localparam int unsigned     XLEN             = 64;
    localparam int unsigned     ILEN             = 32;
    localparam int unsigned     FQ_DEPTH         = 4;
    localparam logic [64-1:0]   RESET_PC_DEFAULT = 64'h0;
    localparam logic [64-1:0]   PC_STEP          = 64'd4;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    // Generate/propagate adder used for the sequential PC step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_add(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] g;
        logic [XLEN-1:0] p;
        logic [XLEN-1:0] c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        for (int i = 0; i < int'(XLEN) - 1; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channel and the decode-side valid/ready channel.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [ILEN-1:0] resp_data;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        output req_valid, req_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        input  req_valid, req_addr, out_valid, out_instr, out_pc
    );

endinterface

// File: rtl/fetch_unit_checker.sv
// Simulation-time protocol and bookkeeping checks for fetch_unit.
module fetch_unit_checker #(
    parameter int unsigned CW = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          resp_valid,
    input logic          iq_full,
    input logic          iq_push,
    input logic          iq_pop,
    input logic          pq_full,
    input logic          pq_push,
    input logic          pq_empty,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] pq_count
);
    a_resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> (outstanding != '0));
    a_iq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (iq_full && iq_push) |-> iq_pop);
    a_pq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        pq_full |-> !pq_push);
    a_pq_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
        pq_count == CW'(outstanding - drop_cnt));
    a_live_resp_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && (drop_cnt == '0)) |-> !pq_empty);
endmodule

// File: rtl/fetch_unit_queue.sv
// fetch_queue: circular FIFO with push/pop/flush and occupancy count. A push into a
// full queue is accepted when a pop happens in the same cycle.
module fetch_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Qualify handshakes and compute next pointers/occupancy.
    always_comb begin
        do_pop_s  = pop && (count_q != '0) && !flush;
        do_push_s = push && !flush && ((count_q != FULL_CNT) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, credit-limited imem requests, instruction queue
// and redirect flush. Optional stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     DEPTH    = FQ_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]   stall_count
`endif
);
    localparam int unsigned   CW       = $clog2(DEPTH) + 1;
    localparam int unsigned   EW       = XLEN + ILEN;
    localparam logic [CW:0]   CRED_LIM = (CW+1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   iq_count_s, pq_count_s;
    logic            iq_full_s, iq_empty_s, pq_full_s, pq_empty_s;
    logic            iq_push_s, iq_pop_s, pq_push_s, pq_pop_s;
    logic [EW-1:0]   iq_wdata_s, iq_rdata_s;
    logic [XLEN-1:0] pq_rdata_s;
    logic            req_valid_s, req_fire_s, live_resp_s;

    // Requests, queue controls, PC, outstanding/drop bookkeeping and next state.
    always_comb begin
        // reset is active low; requests are held off while it is asserted
        req_valid_s = reset && (state_q == ST_FETCH) && !bus.redirect_valid
                      && (({1'b0, iq_count_s} + {1'b0, outstanding_q}) < CRED_LIM);
        req_fire_s  = req_valid_s && bus.req_ready;
        live_resp_s = bus.resp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
        pq_push_s   = req_fire_s;
        pq_pop_s    = live_resp_s;
        iq_push_s   = live_resp_s;
        iq_pop_s    = !iq_empty_s && bus.out_ready && !bus.redirect_valid;
        iq_wdata_s  = {pq_rdata_s, bus.resp_data};

        outstanding_d = outstanding_q + {{(CW-1){1'b0}}, req_fire_s}
                                      - {{(CW-1){1'b0}}, bus.resp_valid};

        if (bus.redirect_valid) begin
            // every response still owed except one arriving right now is stale
            drop_cnt_d = outstanding_q - {{(CW-1){1'b0}}, bus.resp_valid};
            pc_d       = bus.redirect_pc & ~64'h3;
        end else if (req_fire_s) begin
            drop_cnt_d = drop_cnt_q;
            pc_d       = pc_add(pc_q, PC_STEP);
        end else begin
            drop_cnt_d = (bus.resp_valid && (drop_cnt_q != '0)) ? drop_cnt_q - 1'b1 : drop_cnt_q;
            pc_d       = pc_q;
        end

        case (state_q)
            ST_FETCH: state_d = (bus.redirect_valid && (drop_cnt_d != '0)) ? ST_FLUSH : ST_FETCH;
            ST_FLUSH: state_d = (drop_cnt_d == '0) ? ST_FETCH : ST_FLUSH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // State, PC and in-flight counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_queue #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
        .clk   (clk),
        .rst_n (reset),
        .flush (bus.redirect_valid),
        .push  (iq_push_s),
        .wdata (iq_wdata_s),
        .pop   (iq_pop_s),
        .rdata (iq_rdata_s),
        .full  (iq_full_s),
        .empty (iq_empty_s),
        .count (iq_count_s)
    );

    fetch_queue #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (bus.redirect_valid),
        .push  (pq_push_s),
        .wdata (pc_q),
        .pop   (pq_pop_s),
        .rdata (pq_rdata_s),
        .full  (pq_full_s),
        .empty (pq_empty_s),
        .count (pq_count_s)
    );

    assign bus.req_valid = req_valid_s;
    assign bus.req_addr  = pc_q;
    assign bus.out_valid = !iq_empty_s;
    assign bus.out_pc    = iq_empty_s ? '0 : iq_rdata_s[EW-1:ILEN];
    assign bus.out_instr = iq_empty_s ? '0 : iq_rdata_s[ILEN-1:0];

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles decode is starved while fetching normally; saturate at all-ones.
    always_comb begin
        if (iq_empty_s && (state_q == ST_FETCH) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

    fetch_unit_checker #(.CW(CW)) u_checker (
        .clk         (clk),
        .rst_n       (reset),
        .resp_valid  (bus.resp_valid),
        .iq_full     (iq_full_s),
        .iq_push     (iq_push_s),
        .iq_pop      (iq_pop_s),
        .pq_full     (pq_full_s),
        .pq_push     (pq_push_s),
        .pq_empty    (pq_empty_s),
        .outstanding (outstanding_q),
        .drop_cnt    (drop_cnt_q),
        .pq_count    (pq_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// queue-based reference of program order, in-flight requests and decode delivery.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    typedef struct packed { logic [XLEN-1:0] addr; logic stale; } req_t;
    typedef struct packed { logic [XLEN-1:0] pc; logic [ILEN-1:0] instr; } entry_t;

    req_t            inflight[$];   // requests accepted by imem, oldest first
    entry_t          ready_q[$];    // instructions waiting for decode
    logic [XLEN-1:0] fetch_pc;      // next address in program order
    int unsigned     stall_exp;
    int              checks   = 0;
    int              failures = 0;

    function automatic logic [ILEN-1:0] imem_word(input logic [XLEN-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    function automatic bit any_stale();
        foreach (inflight[i]) if (inflight[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the reference, advance the reference.
    task automatic step(input logic rv, input logic [XLEN-1:0] rpc, input logic rq_rdy,
                        input logic rsp, input logic o_rdy);
        logic exp_req, exp_out, rsp_eff;
        req_t r;
        @(negedge clk);
        rsp_eff            = rsp && (inflight.size() > 0);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.req_ready      = rq_rdy;
        bus.resp_valid     = rsp_eff;
        bus.resp_data      = 32'h0;
        if (rsp_eff) bus.resp_data = imem_word(inflight[0].addr);
        bus.out_ready      = o_rdy;
        #1;
        exp_out = (ready_q.size() > 0);
        exp_req = !any_stale() && ((ready_q.size() + inflight.size()) < FQ_DEPTH) && !rv;
        check("req_valid", bus.req_valid, exp_req);
        if (exp_req) check("req_addr", bus.req_addr, fetch_pc);
        check("out_valid", bus.out_valid, exp_out);
        if (exp_out) begin
            check("out_pc", bus.out_pc, ready_q[0].pc);
            check("out_instr", bus.out_instr, ready_q[0].instr);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_count", stall_count, stall_exp);
        if (!exp_out && !any_stale()) stall_exp++;
`endif
        if (rv) begin
            if (rsp_eff) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            ready_q.delete();
            fetch_pc = {rpc[XLEN-1:2], 2'b00};
        end else begin
            if (exp_out && o_rdy) void'(ready_q.pop_front());
            if (rsp_eff) begin
                r = inflight.pop_front();
                if (!r.stale) ready_q.push_back('{r.addr, imem_word(r.addr)});
            end
            if (exp_req && rq_rdy) begin
                inflight.push_back('{fetch_pc, 1'b0});
                fetch_pc = fetch_pc + 64'd4;
            end
        end
    endtask

    // Assert reset between clock edges, check outputs immediately, then release.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = '0;
        bus.out_ready      = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_req_valid", bus.req_valid, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_req_addr", bus.req_addr, RESET_PC_DEFAULT);
        check("rst_out_pc", bus.out_pc, 64'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall_count", stall_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        inflight.delete();
        ready_q.delete();
        fetch_pc  = RESET_PC_DEFAULT;
        // the idle edge between release and the next step is an empty fetch cycle
        stall_exp = 1;
    endtask

    initial begin
        pulse_reset();

        // in-order stream with an always-ready 1-cycle memory
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // decode blocked: credits cap the requests, then drain and resume
        pulse_reset();
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // redirect with three requests in flight and no same-cycle response
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h1002, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // redirect coinciding with a response and a ready memory
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h2000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // fetch address wraps past the top of the address space
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // randomized traffic, including redirects during flush
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(15) == 0), {$urandom(), $urandom()},
                 1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) != 0));
        end

        // reset mid-stream, then restart from the reset PC
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        pulse_reset();
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
